// File: rtl/multiplier.sv
// Two-stage pipelined unsigned multiplier.
// Stage 1 splits b_i into a low and a high half and registers the two
// shifted-AND partial-product sums; stage 2 recombines them into the
// full 2*width_p product. A valid bit travels with the data. Data registers
// only load on valid beats, so c_o stays at zero after reset until the first
// real result arrives.
module multiplier #(
    parameter int width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    output logic                   valid_o,
    output logic [2*width_p-1:0]   c_o
);

    // Product and partial-sum widths. The low half of b_i covers bits
    // [lo_w_lp-1:0], the high half covers the remaining hi_w_lp bits.
    localparam int prod_w_lp   = 2 * width_p;
    localparam int lo_w_lp     = width_p / 2;
    localparam int hi_w_lp     = width_p - lo_w_lp;
    localparam int lo_sum_w_lp = width_p + lo_w_lp;
    localparam int hi_sum_w_lp = width_p + hi_w_lp;

    // Sum of (a AND b_lo[k]) << k over the low half of the multiplier.
    // The result cannot exceed (2^width_p - 1) * (2^lo_w_lp - 1), which fits.
    function automatic logic [lo_sum_w_lp-1:0] pp_sum_lo(
        input logic [width_p-1:0] a,
        input logic [lo_w_lp-1:0] b_lo
    );
        logic [lo_sum_w_lp-1:0] acc;
        logic [lo_sum_w_lp-1:0] a_ext;
        acc   = '0;
        a_ext = lo_sum_w_lp'(a);
        for (int k = 0; k < lo_w_lp; k++) begin
            acc = acc + ({lo_sum_w_lp{b_lo[k]}} & (a_ext << k));
        end
        return acc;
    endfunction

    // Sum of (a AND b_hi[k]) << k over the high half, weighted relative to
    // bit lo_w_lp of b; the stage-2 shift restores the absolute weight.
    function automatic logic [hi_sum_w_lp-1:0] pp_sum_hi(
        input logic [width_p-1:0] a,
        input logic [hi_w_lp-1:0] b_hi
    );
        logic [hi_sum_w_lp-1:0] acc;
        logic [hi_sum_w_lp-1:0] a_ext;
        acc   = '0;
        a_ext = hi_sum_w_lp'(a);
        for (int k = 0; k < hi_w_lp; k++) begin
            acc = acc + ({hi_sum_w_lp{b_hi[k]}} & (a_ext << k));
        end
        return acc;
    endfunction

    // Recombine the two partial sums into the full-precision product.
    function automatic logic [prod_w_lp-1:0] combine_sums(
        input logic [lo_sum_w_lp-1:0] lo_sum,
        input logic [hi_sum_w_lp-1:0] hi_sum
    );
        return prod_w_lp'(lo_sum) + (prod_w_lp'(hi_sum) << lo_w_lp);
    endfunction

    // Stage 1 state
    logic                   valid1_q, valid1_d;
    logic [lo_sum_w_lp-1:0] lo_sum_q, lo_sum_d;
    logic [hi_sum_w_lp-1:0] hi_sum_q, hi_sum_d;

    // Stage 2 state (drives the outputs directly)
    logic                   valid2_q, valid2_d;
    logic [prod_w_lp-1:0]   prod_q,   prod_d;

    // Stage 1 next state: partial sums load only on a valid input beat.
    always_comb begin
        valid1_d = valid_i;
        lo_sum_d = lo_sum_q;
        hi_sum_d = hi_sum_q;
        if (valid_i) begin
            lo_sum_d = pp_sum_lo(a_i, b_i[lo_w_lp-1:0]);
            hi_sum_d = pp_sum_hi(a_i, b_i[width_p-1:lo_w_lp]);
        end else begin
            lo_sum_d = lo_sum_q;
            hi_sum_d = hi_sum_q;
        end
    end

    // Stage 2 next state: the product loads only when stage 1 holds a valid pair.
    always_comb begin
        valid2_d = valid1_q;
        prod_d   = prod_q;
        if (valid1_q) begin
            prod_d = combine_sums(lo_sum_q, hi_sum_q);
        end else begin
            prod_d = prod_q;
        end
    end

    // Pipeline registers with synchronous reset clearing valid and data alike.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid1_q <= 1'b0;
            lo_sum_q <= '0;
            hi_sum_q <= '0;
            valid2_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            valid1_q <= valid1_d;
            lo_sum_q <= lo_sum_d;
            hi_sum_q <= hi_sum_d;
            valid2_q <= valid2_d;
            prod_q   <= prod_d;
        end
    end

    assign valid_o = valid2_q;
    assign c_o     = prod_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the two-stage multiplier. The reference model is a
// two-deep delay queue of (valid, a*b) entries computed with plain arithmetic.
module tb_multiplier;

    localparam int W = 16;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            valid_i = 1'b0;
    logic [W-1:0]    a_i = '0;
    logic [W-1:0]    b_i = '0;
    logic            valid_o;
    logic [2*W-1:0]  c_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic           mv[$];
    logic [2*W-1:0] mc[$];
    logic           exp_v;
    logic [2*W-1:0] exp_c;

    multiplier #(.width_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .c_o     (c_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rst);
        logic [2*W-1:0] p;
        reset_i = rst;
        valid_i = v;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        if (rst) begin
            mv.delete();
            mc.delete();
        end else begin
            p = (2*W)'(a) * (2*W)'(b);
            mv.push_back(v);
            mc.push_back(p);
            if (mv.size() > 2) begin
                void'(mv.pop_front());
                void'(mc.pop_front());
            end
        end
        if (mv.size() == 2) begin
            exp_v = mv[0];
            exp_c = mc[0];
        end else begin
            exp_v = 1'b0;
            exp_c = '0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'd5, 16'd7, 1'b1);
            checks++;
            if (valid_o !== 1'b0 || c_o !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold: valid_o=%b c_o=%0d expected valid_o=0 c_o=0", valid_o, c_o);
            end
        end
        // First edge after release: still nothing out, data still zero.
        step(1'b1, 16'd5, 16'd7, 1'b0);
        checks++;
        if (valid_o !== 1'b0 || c_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: valid_o=%b c_o=%0d expected valid_o=0 c_o=0", valid_o, c_o);
        end
        step(1'b0, 16'd0, 16'd0, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || c_o !== 32'd35) begin
            errors++;
            $display("FAIL reset_first_result: valid_o=%b c_o=%0d expected valid_o=1 c_o=35", valid_o, c_o);
        end
        step(1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta[6];
        logic [W-1:0]   tb[6];
        logic [2*W-1:0] tp[6];
        ta = '{16'd0, 16'd1, 16'd65535, 16'd65535, 16'd32768, 16'd1000};
        tb = '{16'd65535, 16'd65535, 16'd1, 16'd65535, 16'd2, 16'd64000};
        tp = '{32'd0, 32'd65535, 32'd65535, 32'hFFFE0001, 32'd65536, 32'd64000000};
        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(1'b1, ta[i], tb[i], 1'b0);
            else       step(1'b0, 16'd0, 16'd0, 1'b0);
            if (i >= 1 && i <= 6) begin
                checks++;
                if (valid_o !== 1'b1 || c_o !== tp[i-1]) begin
                    errors++;
                    $display("FAIL directed[%0d]: valid_o=%b c_o=%0d expected valid_o=1 c_o=%0d",
                             i-1, valid_o, c_o, tp[i-1]);
                end
            end
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL directed_drain: valid_o=%b expected 0", valid_o);
        end
    endtask

    task automatic test_sweep();
        int n = 0;
        for (int a = 0; a <= 65000; a += 1000) begin
            for (int b = 0; b <= 65000; b += 1000) begin
                step(1'b1, W'(a), W'(b), 1'b0);
                if (n > 0) begin
                    checks++;
                    if (valid_o !== exp_v || valid_o !== 1'b1 || c_o !== exp_c) begin
                        errors++;
                        $display("FAIL sweep[%0d]: valid_o=%b c_o=%0d expected valid_o=1 c_o=%0d",
                                 n, valid_o, c_o, exp_c);
                    end
                end
                n++;
            end
        end
        step(1'b0, 16'd0, 16'd0, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || c_o !== 32'd4225000000) begin
            errors++;
            $display("FAIL sweep_last: valid_o=%b c_o=%0d expected valid_o=1 c_o=4225000000", valid_o, c_o);
        end
        step(1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_bubbles();
        logic           vp[5];
        logic [W-1:0]   ba[5];
        logic [W-1:0]   bb[5];
        logic [2*W-1:0] prod_exp[5];
        vp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ba = '{16'd3, 16'd0, 16'd6, 16'd100, 16'd0};
        bb = '{16'd4, 16'd0, 16'd7, 16'd200, 16'd0};
        prod_exp = '{32'd12, 32'd0, 32'd42, 32'd20000, 32'd0};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(vp[i], (vp[i] ? ba[i] : W'($urandom)), (vp[i] ? bb[i] : W'($urandom)), 1'b0);
            else       step(1'b0, 16'd0, 16'd0, 1'b0);
            if (i >= 1) begin
                checks++;
                if (valid_o !== vp[i-1] || (vp[i-1] && c_o !== prod_exp[i-1])) begin
                    errors++;
                    $display("FAIL bubbles[%0d]: valid_o=%b c_o=%0d expected valid_o=%b c_o=%0d",
                             i-1, valid_o, c_o, vp[i-1], prod_exp[i-1]);
                end
            end
        end
        step(1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 16'd9, 16'd9, 1'b0);
        step(1'b1, 16'd10, 16'd10, 1'b1);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flush: valid_o=%b c_o=%0d expected valid_o=0", valid_o, c_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step(1'b1, 16'd2, 16'd3, 1'b0);
            else        step(1'b0, 16'd0, 16'd0, 1'b0);
            checks++;
            if (i == 1) begin
                if (valid_o !== 1'b1 || c_o !== 32'd6) begin
                    errors++;
                    $display("FAIL midreset_first: valid_o=%b c_o=%0d expected valid_o=1 c_o=6", valid_o, c_o);
                end
            end else begin
                if (valid_o !== 1'b0 || (i == 0 && c_o !== 32'd0)) begin
                    errors++;
                    $display("FAIL midreset_idle[%0d]: valid_o=%b c_o=%0d expected valid_o=0", i, valid_o, c_o);
                end
            end
        end
    endtask

    task automatic test_random();
        logic v, r;
        logic [W-1:0] a, b;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       begin a = 16'hFFFF;     b = W'($urandom); end
                1:       begin a = W'($urandom); b = 16'hFFFF;     end
                default: begin a = W'($urandom); b = W'($urandom); end
            endcase
            step(v, a, b, r);
            checks++;
            if (valid_o !== exp_v || (exp_v && c_o !== exp_c)) begin
                errors++;
                $display("FAIL random[%0d]: valid_o=%b c_o=%0d expected valid_o=%b c_o=%0d",
                         i, valid_o, c_o, exp_v, exp_c);
            end
        end
    endtask

    initial begin
        exp_v = 1'b0;
        exp_c = '0;
        test_reset();
        test_directed();
        test_sweep();
        test_bubbles();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Unsigned integer multiplier: c_o = a_i * b_i, full-precision product of width 2*width_p.
- Fully pipelined, fixed 2-cycle latency, one new operand pair accepted every cycle, no backpressure.
- Sits in the datapath as a drop-in arithmetic unit.
- A valid bit travels alongside the data so consumers know when c_o is meaningful.

Parameters:
- width_p, 16, bit width of each operand; product width is 2*width_p. Legal range 2..32.

Ports:
- clk_i  input  1  rising-edge clock
- reset_i  input  1  synchronous, active-high reset
- valid_i  input  1  a_i/b_i carry a valid operand pair this cycle
- a_i  input  width_p  multiplicand, unsigned
- b_i  input  width_p  multiplier, unsigned
- valid_o  output  1  c_o holds a valid product this cycle
- c_o  output  2*width_p  unsigned product a_i*b_i of the pair presented 2 cycles earlier

Behaviour:
- Clocking/reset:
  - One clock (clk_i).
  - Reset is synchronous and active-high (reset_i sampled on the rising clk_i edge).
  - While reset_i is high at a clock edge, all pipeline valid bits and data registers clear to 0.
  - c_o = 0 and valid_o = 0 from the first edge with reset_i high until the first result after reset is released.
- Arithmetic:
  - Unsigned multiply, no truncation, no overflow possible: c_o == a_i * b_i exactly in 2*width_p bits.
  - Maximum result is (2^width_p - 1)^2; for width_p = 16 this is 4294836225 = 0xFFFE0001.
- Pipeline structure:
  - Stage 1 (edge N): register the partial-product sums. Generate width_p partial products (a_i AND b_i[k]) << k, reduce them to two or more partial sums (e.g. a low-half and high-half of b_i), and register these along with valid_i.
  - Stage 2 (edge N+1): add the registered partial sums and register the result into c_o; register stage-1 valid into valid_o.
  - Latency: a pair sampled at edge N appears on c_o/valid_o after edge N+1, i.e. 2 edges.
  - Throughput: 1 pair per cycle.
- Valid handling:
  - valid_i = 0 bubbles propagate as valid_o = 0 two cycles later.
  - Data registers are not cleared on bubbles. c_o is don't-care when valid_o = 0, except after reset, when it is 0.
  - Back-to-back valid pairs produce back-to-back valid results in the same order.
- Reset mid-operation: asserting reset_i discards all in-flight pairs. No result for pairs accepted before reset ever appears with valid_o = 1.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.
- No combinational path from inputs to outputs. All outputs are driven directly from flops.

Test Plan:
- Reset: hold reset_i = 1 for 2 cycles with valid_i = 1, a_i = 5, b_i = 7 -> valid_o = 0, c_o = 0 throughout and 2 cycles after release until the new result.
- Zero and identity: (0, 65535) -> 0; (1, 65535) -> 65535; (65535, 1) -> 65535, each on c_o 2 cycles after presentation with valid_o = 1.
- Extremes: (65535, 65535) -> 4294836225 (0xFFFE0001); (32768, 2) -> 65536; (1000, 64000) -> 64000000.
- Sweep: a and b from 0 to 65000 in steps of 1000, one pair per cycle back-to-back. Check every c_o against the golden a*b with 2-cycle alignment -> zero mismatches, valid_o continuously 1.
- Bubbles: valid pattern 1,0,1,1,0 with pairs (3,4), (x,x), (6,7), (100,200), (x,x) -> valid_o pattern 1,0,1,1,0 delayed 2 cycles; valid products 12, 42, 20000.
- Reset mid-stream: present (9,9) then (10,10), assert reset_i on the next edge -> neither 81 nor 100 appears with valid_o = 1. The first pair after deassert, (2,3), yields 6 two cycles later.
